// File: rtl/fetch_ctrl.sv
// Program-counter sequencer for the 9-bit CPU: drives the ROM address, presents the
// fetched word to decode in the same cycle, applies stall/jump/branch redirects, and stops on the halt opcode.
module fetch_ctrl #(
  parameter int             D          = 12,
  parameter logic [D-1:0]   START_ADDR = '0,
  parameter logic [8:0]     HALT_CODE  = 9'b111111111,
  parameter int             OFS_W      = 8,
  parameter int             CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic             jump_en,
  input  logic [D-1:0]     jump_addr,
  input  logic             branch_en,
  input  logic [OFS_W-1:0] branch_ofs,
  input  logic [8:0]       mach_code,
  output logic [D-1:0]     prog_ctr_out,
  output logic [8:0]       instr,
  output logic             instr_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  localparam logic [D-1:0]     PC_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t           r_state, w_state_nxt;
  logic [D-1:0]     r_pc, w_pc_nxt;
  logic             r_done, w_done_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  logic             w_is_halt;
  logic [D-1:0]     w_ofs_ext;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_is_halt = (mach_code == HALT_CODE);
  // Offset is sign-extended to the PC width so negative branches wrap modulo the ROM size.
  assign w_ofs_ext = {{(D-OFS_W){branch_ofs[OFS_W-1]}}, branch_ofs};
  assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_ONE;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pc    <= START_ADDR;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_done  <= w_done_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_done_nxt  = r_done;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE, S_HALT: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_pc_nxt    = START_ADDR;
          w_done_nxt  = 1'b0;
          w_cnt_nxt   = '0;
        end
      end
      S_RUN: begin
        // Every RUN cycle counts, including stalls and the halt cycle itself.
        w_cnt_nxt = w_cnt_inc;
        if (stall) begin
          w_pc_nxt = r_pc;
        end else if (w_is_halt) begin
          w_state_nxt = S_HALT;
          w_done_nxt  = 1'b1;
        end else if (jump_en) begin
          w_pc_nxt = jump_addr;
        end else if (branch_en) begin
          w_pc_nxt = r_pc + w_ofs_ext;
        end else begin
          w_pc_nxt = r_pc + PC_ONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign prog_ctr_out = r_pc;
  assign instr_valid  = (r_state == S_RUN);
  assign busy         = (r_state == S_RUN);
  assign instr        = (r_state == S_RUN) ? mach_code : 9'b0;
  assign done         = r_done;
  assign cycle_count  = r_cnt;

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Program-counter sequencer for the 9-bit CPU's instruction ROM.
- Owns `prog_ctr_out`, which drives the ROM address, and receives the combinational `mach_code` back from the ROM.
- Presents the fetched instruction to decode, applies stall/jump/branch redirects from the core, detects the halt opcode, and reports run status and cycle count to the testbench/top level.

Parameters:
- D, 12, PC/address width; ROM depth is 2**D.
- START_ADDR, 0, PC value loaded on reset and on every start.
- HALT_CODE, 9'b111111111, machine word that ends program execution.
- OFS_W, 8, width of the signed relative-branch offset.
- CNT_W, 16, width of the cycle counter.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- reset, input, 1, synchronous active-high reset.
- start, input, 1, one-cycle request to begin execution from START_ADDR.
- stall, input, 1, hold the PC and the current instruction this cycle.
- jump_en, input, 1, absolute redirect request.
- jump_addr, input, D, absolute target address.
- branch_en, input, 1, relative redirect request.
- branch_ofs, input, OFS_W, two's-complement offset relative to the current PC.
- mach_code, input, 9, instruction word returned by the ROM for `prog_ctr_out`.
- prog_ctr_out, output, D, ROM address / current PC.
- instr, output, 9, instruction presented to decode.
- instr_valid, output, 1, `instr` is a live instruction this cycle.
- busy, output, 1, high while in RUN.
- done, output, 1, sticky program-complete flag.
- cycle_count, output, CNT_W, number of RUN cycles since the last start.

Behaviour:
- States: IDLE, RUN, HALT. Encoding is free; only observable outputs are specified.
- Reset (sampled at clock edge, overrides everything, including mid-RUN):
  - state=IDLE, prog_ctr_out=START_ADDR, done=0, cycle_count=0.
  - instr_valid=0 and busy=0 (derived from state).
- Combinational outputs:
  - instr = mach_code when state==RUN, else 9'b0.
  - instr_valid = (state==RUN); busy = (state==RUN).
  - There is no added fetch latency: the instruction at PC is visible in the same cycle the PC is driven.
- IDLE:
  - start=1 -> next state RUN, PC=START_ADDR, cycle_count=0, done=0.
  - All redirect and stall inputs are ignored.
- RUN, per clock edge, with priority high to low:
  1. stall=1: PC holds; jump/branch/halt are ignored this cycle.
  2. mach_code==HALT_CODE: next state HALT, PC holds at the halt address, done=1. A jump or branch asserted in the same cycle is ignored.
  3. jump_en=1: PC=jump_addr. Jump wins over branch when both are asserted.
  4. branch_en=1: PC = (PC + sign-extend(branch_ofs)) mod 2**D.
  5. Otherwise PC = (PC + 1) mod 2**D. From 2**D-1 the PC wraps to 0 with no error flag.
- cycle_count in RUN:
  - Increments by 1 every RUN cycle, including stall cycles and the halt cycle.
  - Saturates at 2**CNT_W-1; it does not wrap.
- start while in RUN is ignored.
- HALT:
  - PC, cycle_count and done=1 hold; instr_valid=0.
  - start=1 -> RUN with PC=START_ADDR, cycle_count=0, done=0.
- All arithmetic is unsigned modulo 2**D except the sign extension of branch_ofs. A negative offset below 0 wraps to the top of the ROM.

Test Plan:
- Reset, then start pulse; ROM words at 0..3 are 9'h07E, 9'h066, 9'h07A, 9'h1FF (halt) -> PC sequence 0,1,2,3; instr_valid high for 4 cycles; done=1 and state HALT from the cycle after PC=3; PC holds at 3; cycle_count=4.
- In RUN at PC=5: assert stall for 3 cycles -> PC stays 5, instr stays mach_code[5], cycle_count +3. Then jump_en=1 and branch_en=1 together with jump_addr=12'h040 -> next PC=0x040.
- At PC=0x010: branch_en with branch_ofs=8'hFC (-4) -> next PC=0x00C. At PC=0x002: branch_ofs=8'hFB (-5) -> next PC=0xFFD (wrap).
- Sequential run through address 0xFFF with no halt -> next PC=0x000; done stays 0; busy stays 1.
- Halt opcode with stall=1 in the same cycle -> no halt until stall drops. Then start in HALT -> PC=START_ADDR, done=0, cycle_count=0 on the next cycle.
- Reset asserted mid-RUN at PC=0x123 with jump_en=1 -> next cycle IDLE, PC=START_ADDR, instr=0, instr_valid=0, done=0, cycle_count=0.
